// File: rtl/bcd_display_mux.sv
// Four-digit multiplexed seven-segment driver for packed BCD input.
// The value is snapshotted once per frame so that a mid-frame update cannot tear the display.
module bcd_display_mux #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bcd,
    input  logic        blank_lz,
    input  logic        dp_en,
    input  logic [1:0]  dp_pos,
    output logic [3:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [CW-1:0] cnt;
    logic [1:0]    digit;
    logic [15:0]   bcd_q;
    logic          load_pend;

    logic [3:0]    nibble;
    logic          guard;
    logic          blanked;
    logic [6:0]    glyph;
    logic [3:0]    an_next;
    logic [6:0]    seg_next;
    logic          dp_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            digit <= 2'd0;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            digit <= digit + 2'd1;
        end else begin
            cnt   <= cnt + CNT_ONE;
        end
    end

    // bcd is captured only on the first edge after reset and when entering digit 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd_q     <= 16'h0000;
            load_pend <= 1'b1;
        end else if (load_pend) begin
            bcd_q     <= bcd;
            load_pend <= 1'b0;
        end else if (digit == 2'd3 && cnt == CNT_LAST) begin
            bcd_q     <= bcd;
        end
    end

    always_comb begin
        nibble = bcd_q[{digit, 2'b00} +: 4];
        guard  = (cnt < CNT_BLANK);

        // A digit is a leading zero when it and everything above it are zero.
        case (digit)
            2'd1:    blanked = blank_lz && (bcd_q[15:4] == 12'd0);
            2'd2:    blanked = blank_lz && (bcd_q[15:8] == 8'd0);
            2'd3:    blanked = blank_lz && (bcd_q[15:12] == 4'd0);
            default: blanked = 1'b0;
        endcase

        case (nibble)
            4'd0:    glyph = 7'h40;
            4'd1:    glyph = 7'h79;
            4'd2:    glyph = 7'h24;
            4'd3:    glyph = 7'h30;
            4'd4:    glyph = 7'h19;
            4'd5:    glyph = 7'h12;
            4'd6:    glyph = 7'h02;
            4'd7:    glyph = 7'h78;
            4'd8:    glyph = 7'h00;
            4'd9:    glyph = 7'h10;
            default: glyph = 7'h3F;
        endcase

        if (guard || blanked) begin
            an_next  = 4'hF;
            seg_next = 7'h7F;
            dp_next  = 1'b1;
        end else begin
            an_next  = ~(4'b0001 << digit);
            seg_next = glyph;
            dp_next  = ~(dp_en && (dp_pos == digit));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_n  <= 4'hF;
            seg_n <= 7'h7F;
            dp_n  <= 1'b1;
        end else begin
            an_n  <= an_next;
            seg_n <= seg_next;
            dp_n  <= dp_next;
        end
    end

endmodule

// File: tb/tb_bcd_display_mux.sv
// Bench for bcd_display_mux: a frame-position reference model plus directed and random scenarios.
module tb_bcd_display_mux;

    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = 4 * RD;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bcd;
    logic        blank_lz;
    logic        dp_en;
    logic [1:0]  dp_pos;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;

    int checks = 0;
    int errors = 0;

    int          pos;
    int          exp_p;
    logic [15:0] snap;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;

    bcd_display_mux #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
        .clk(clk), .reset(reset), .bcd(bcd), .blank_lz(blank_lz),
        .dp_en(dp_en), .dp_pos(dp_pos), .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph_of(input logic [3:0] n);
        case (n)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // Outputs after an edge describe the frame position reached before that edge.
    task automatic tick();
        int d;
        int c;
        bit blk;
        exp_p = pos;
        c = pos % RD;
        d = (pos / RD) % 4;
        blk = blank_lz && (d >= 1) && ((snap >> (4 * d)) == 16'd0);
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
        exp_dp  = 1'b1;
        if (c >= BC && !blk) begin
            exp_an[d] = 1'b0;
            exp_seg   = glyph_of(snap[4*d +: 4]);
            exp_dp    = !(dp_en && int'(dp_pos) == d);
        end
        @(posedge clk);
        if (pos == 0 || pos % FRAME == FRAME - 1) snap = bcd;
        pos++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        pos = 0;
        snap = 16'h0000;
    endtask

    task automatic test_reset();
        bcd = 16'h9999; blank_lz = 1'b0; dp_en = 1'b1; dp_pos = 2'd0;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (an_n !== 4'hF || seg_n !== 7'h7F || dp_n !== 1'b1) begin
                errors++;
                $display("[TB] FAIL reset_hold cyc=%0d got an=%h seg=%h dp=%b exp an=f seg=7f dp=1", i, an_n, seg_n, dp_n);
            end
        end
        reset = 1'b0;
        pos = 0;
        snap = 16'h0000;
        tick();
        checks++;
        if (an_n !== 4'hF || seg_n !== 7'h7F || dp_n !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_first_edge got an=%h seg=%h dp=%b exp an=f seg=7f dp=1", an_n, seg_n, dp_n);
        end
        tick();
        tick();
        checks++;
        if (an_n !== 4'b1110 || seg_n !== 7'h10 || dp_n !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_then_drive got an=%h seg=%h dp=%b exp an=e seg=10 dp=0", an_n, seg_n, dp_n);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (an_n !== 4'hF || seg_n !== 7'h7F || dp_n !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_async got an=%h seg=%h dp=%b exp an=f seg=7f dp=1", an_n, seg_n, dp_n);
        end
        @(negedge clk);
        reset = 1'b0;
        pos = 0;
        snap = 16'h0000;
    endtask

    task automatic test_basic_scan();
        logic [3:0] an_tab [4];
        logic [6:0] seg_tab [4];
        an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_tab = '{7'h19, 7'h30, 7'h24, 7'h79};
        bcd = 16'h1234; blank_lz = 1'b0; dp_en = 1'b0; dp_pos = 2'd0;
        do_reset();
        for (int i = 0; i < 2 * FRAME + 1; i++) begin
            tick();
            checks++;
            if (an_n !== exp_an || seg_n !== exp_seg || dp_n !== exp_dp) begin
                errors++;
                $display("[TB] FAIL scan_model p=%0d got %h/%h/%b exp %h/%h/%b", exp_p, an_n, seg_n, dp_n, exp_an, exp_seg, exp_dp);
            end
            if (exp_p >= 1 && exp_p % RD >= BC) begin
                checks++;
                if (an_n !== an_tab[(exp_p / RD) % 4] || seg_n !== seg_tab[(exp_p / RD) % 4]) begin
                    errors++;
                    $display("[TB] FAIL scan_const p=%0d got an=%h seg=%h", exp_p, an_n, seg_n);
                end
            end else begin
                checks++;
                if (an_n !== 4'hF) begin
                    errors++;
                    $display("[TB] FAIL scan_guard p=%0d got an=%h exp f", exp_p, an_n);
                end
            end
        end
    endtask

    task automatic run_frame_model(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            checks++;
            if (an_n !== exp_an || seg_n !== exp_seg || dp_n !== exp_dp) begin
                errors++;
                $display("[TB] FAIL %s p=%0d got %h/%h/%b exp %h/%h/%b", name, exp_p, an_n, seg_n, dp_n, exp_an, exp_seg, exp_dp);
            end
        end
    endtask

    task automatic test_leading_zeros();
        bcd = 16'h0045; blank_lz = 1'b1; dp_en = 1'b0; dp_pos = 2'd0;
        do_reset();
        for (int i = 0; i < FRAME + 1; i++) begin
            tick();
            if (exp_p >= 1 && exp_p % RD >= BC) begin
                checks++;
                case ((exp_p / RD) % 4)
                    0: if (an_n !== 4'b1110 || seg_n !== 7'h12) begin errors++; $display("[TB] FAIL lz_d0 got an=%h seg=%h exp e/12", an_n, seg_n); end
                    1: if (an_n !== 4'b1101 || seg_n !== 7'h19) begin errors++; $display("[TB] FAIL lz_d1 got an=%h seg=%h exp d/19", an_n, seg_n); end
                    default: if (an_n !== 4'hF || seg_n !== 7'h7F) begin errors++; $display("[TB] FAIL lz_blank p=%0d got an=%h seg=%h exp f/7f", exp_p, an_n, seg_n); end
                endcase
            end
        end
        bcd = 16'h0000;
        do_reset();
        for (int i = 0; i < FRAME + 1; i++) begin
            tick();
            checks++;
            if (an_n !== exp_an || seg_n !== exp_seg || dp_n !== exp_dp) begin
                errors++;
                $display("[TB] FAIL lz_zero p=%0d got %h/%h/%b exp %h/%h/%b", exp_p, an_n, seg_n, dp_n, exp_an, exp_seg, exp_dp);
            end
            if (exp_p % RD >= BC && (exp_p / RD) % 4 == 0) begin
                checks++;
                if (seg_n !== 7'h40 || an_n !== 4'b1110) begin
                    errors++;
                    $display("[TB] FAIL lz_zero_d0 got an=%h seg=%h exp e/40", an_n, seg_n);
                end
            end
        end
    endtask

    task automatic test_tear_free();
        logic [6:0] f0 [4];
        logic [6:0] f1 [4];
        f0 = '{7'h19, 7'h30, 7'h24, 7'h79};
        f1 = '{7'h00, 7'h78, 7'h02, 7'h12};
        bcd = 16'h1234; blank_lz = 1'b0; dp_en = 1'b0; dp_pos = 2'd0;
        do_reset();
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (pos == RD + 2) bcd = 16'h5678;
            tick();
            checks++;
            if (an_n !== exp_an || seg_n !== exp_seg) begin
                errors++;
                $display("[TB] FAIL tear_model p=%0d got %h/%h exp %h/%h", exp_p, an_n, seg_n, exp_an, exp_seg);
            end
            if (exp_p >= 1 && exp_p % RD >= BC) begin
                checks++;
                if (seg_n !== (exp_p < FRAME ? f0[(exp_p / RD) % 4] : f1[(exp_p / RD) % 4])) begin
                    errors++;
                    $display("[TB] FAIL tear_const p=%0d got seg=%h", exp_p, seg_n);
                end
            end
        end
    endtask

    task automatic test_invalid();
        bcd = 16'h00A0; blank_lz = 1'b1; dp_en = 1'b0; dp_pos = 2'd0;
        do_reset();
        run_frame_model("invalid_model", FRAME + 1);
        tick();
        tick();
        tick();
        checks++;
        if (an_n !== 4'b1110 || seg_n !== 7'h40) begin
            errors++;
            $display("[TB] FAIL invalid_d0 got an=%h seg=%h exp e/40", an_n, seg_n);
        end
        for (int i = 0; i < RD; i++) tick();
        checks++;
        if (an_n !== 4'b1101 || seg_n !== 7'h3F) begin
            errors++;
            $display("[TB] FAIL invalid_d1 got an=%h seg=%h exp d/3f", an_n, seg_n);
        end
    endtask

    task automatic test_decimal_point();
        int lows;
        bcd = 16'h0123; blank_lz = 1'b1; dp_en = 1'b1; dp_pos = 2'd2;
        do_reset();
        lows = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (dp_n === 1'b0) lows++;
            checks++;
            if (dp_n !== exp_dp || an_n !== exp_an) begin
                errors++;
                $display("[TB] FAIL dp_model p=%0d got dp=%b an=%h exp dp=%b an=%h", exp_p, dp_n, an_n, exp_dp, exp_an);
            end
        end
        checks++;
        if (lows != RD - BC) begin
            errors++;
            $display("[TB] FAIL dp_pos2_count got %0d exp %0d", lows, RD - BC);
        end
        dp_pos = 2'd3;
        lows = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (dp_n === 1'b0) lows++;
        end
        checks++;
        if (lows != 0) begin
            errors++;
            $display("[TB] FAIL dp_pos3_count got %0d exp 0", lows);
        end
    endtask

    task automatic test_random();
        logic [15:0] masks [4];
        masks = '{16'h000F, 16'h00FF, 16'h0FFF, 16'hFFFF};
        bcd = 16'h0000; blank_lz = 1'b0; dp_en = 1'b0; dp_pos = 2'd0;
        do_reset();
        for (int i = 0; i < 10 * FRAME; i++) begin
            if ($urandom_range(0, 9) == 0) bcd = 16'($urandom) & masks[$urandom_range(0, 3)];
            if ($urandom_range(0, 4) == 0) blank_lz = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) dp_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) dp_pos = 2'($urandom_range(0, 3));
            tick();
            checks++;
            if (an_n !== exp_an || seg_n !== exp_seg || dp_n !== exp_dp) begin
                errors++;
                $display("[TB] FAIL random p=%0d got %h/%h/%b exp %h/%h/%b", exp_p, an_n, seg_n, dp_n, exp_an, exp_seg, exp_dp);
            end
            checks++;
            if ($countones(~an_n) > 1) begin
                errors++;
                $display("[TB] FAIL one_anode p=%0d got an=%h exp at most one low", exp_p, an_n);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bcd = 16'h0000; blank_lz = 1'b0; dp_en = 1'b0; dp_pos = 2'd0;
        pos = 0; exp_p = 0; snap = 16'h0000;
        exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic_scan();
        test_leading_zeros();
        test_tear_free();
        test_invalid();
        test_decimal_point();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
